reg_scoreboard: RTL and testbench

- Tracks in-flight destination registers for the pipeline; the consumer of the 5-bit destination-select mux output.
- At ID, records each register-writing instruction's destination. At WB, releases that destination when the write is retired.
- Gives the hazard logic a stall signal whenever a source register has a write still pending, or a destination's counter is full.
- Sits between the ID-stage destination mux and the ID/EX pipeline-register enable.

---
 rtl/sb_pkg.sv | 12 +
 rtl/sb_counter.sv | 33 +++
 rtl/reg_scoreboard.sv | 83 ++++++++
 tb/tb_reg_scoreboard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and types for the register scoreboard
package sb_pkg;
    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int CNT_W_DEF    = 2;
    localparam int TOT_W_DEF    = 7;
    localparam int CNT_MAX      = 3;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register saturating pending-write counter
module sb_counter import sb_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero,
    output logic             is_one,
    output logic             is_full,
    output logic             underflow
);
    assign is_zero   = (cnt == '0);
    assign is_one    = (cnt == CNT_W'(1));
    assign is_full   = (cnt == CNT_W'(CNT_MAX));
    // A retire against an empty counter is dropped; flush discards it entirely.
    assign underflow = dec && is_zero && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !is_full && !(dec && !is_zero)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !is_zero && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight destination tracking and ID-stage RAW stall
module reg_scoreboard import sb_pkg::*; #(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TOT_W    = TOT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_used,
    input  logic              retire_valid,
    input  logic [ADDR_W-1:0] retire_dest,
    input  logic              flush,
    output logic              stall,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [TOT_W-1:0]  inflight,
    output logic              err_underflow
);
    logic [CNT_W-1:0]    cnt_v [NUM_REGS];
    logic [NUM_REGS-1:0] zero_v, one_v, full_v, uf_v;
    logic                rs_raw, rs_byp, rt_raw, rt_byp;
    logic                dest_full, accept, retire_ok;

    // r0 is hardwired: never pending, never full, never underflows.
    assign cnt_v[0]  = '0;
    assign zero_v[0] = 1'b1;
    assign one_v[0]  = 1'b0;
    assign full_v[0] = 1'b0;
    assign uf_v[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (flush),
            .inc       (accept && (issue_dest == ADDR_W'(r))),
            .dec       (retire_valid && (retire_dest == ADDR_W'(r))),
            .cnt       (cnt_v[r]),
            .is_zero   (zero_v[r]),
            .is_one    (one_v[r]),
            .is_full   (full_v[r]),
            .underflow (uf_v[r])
        );
    end

    // WB writes in the first half-cycle, so the last pending write retiring now clears the hazard.
    assign rs_raw  = (cnt_v[rs_addr] != '0);
    assign rs_byp  = retire_valid && (retire_dest == rs_addr) && one_v[rs_addr];
    assign rt_raw  = (cnt_v[rt_addr] != '0);
    assign rt_byp  = retire_valid && (retire_dest == rt_addr) && one_v[rt_addr];
    assign rs_busy = rs_used && rs_raw && !rs_byp;
    assign rt_busy = rt_used && rt_raw && !rt_byp;

    assign dest_full = issue_valid && issue_we && (issue_dest != REG_ZERO) && full_v[issue_dest];
    assign stall     = issue_valid && (rs_busy || rt_busy || dest_full);
    assign accept    = issue_valid && issue_we && (issue_dest != REG_ZERO) && !stall;
    assign retire_ok = retire_valid && (retire_dest != REG_ZERO) && !zero_v[retire_dest];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + TOT_W'(accept) - TOT_W'(retire_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (|uf_v) begin
            err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed table plus randomized model check of reg_scoreboard
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_we;
    logic [4:0] issue_dest, rs_addr, rt_addr, retire_dest;
    logic       rs_used, rt_used, retire_valid, flush;
    logic       stall, rs_busy, rt_busy, err_underflow;
    logic [6:0] inflight;

    int n_pass = 0;
    int n_total = 0;

    int  mcnt [32];
    bit  merr;

    typedef struct {
        bit       rst_n;
        bit       iv;
        bit       we;
        bit [4:0] dest;
        bit [4:0] rs;
        bit       rsu;
        bit [4:0] rt;
        bit       rtu;
        bit       rv;
        bit [4:0] rd;
        bit       fl;
        int       e_stall;
        int       e_rsb;
        int       e_rtb;
        int       e_inf;
        int       e_err;
    } vec_t;

    vec_t tbl [$];

    reg_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_dest    (issue_dest),
        .rs_addr       (rs_addr),
        .rs_used       (rs_used),
        .rt_addr       (rt_addr),
        .rt_used       (rt_used),
        .retire_valid  (retire_valid),
        .retire_dest   (retire_dest),
        .flush         (flush),
        .stall         (stall),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit iv, bit we, int d, int rs, bit rsu, int rt, bit rtu,
                                bit rv, int rd, bit fl, int st, int rsb, int rtb, int inf, int er);
        vec_t v;
        v.rst_n = r;  v.iv = iv; v.we = we; v.dest = 5'(d);
        v.rs = 5'(rs); v.rsu = rsu; v.rt = 5'(rt); v.rtu = rtu;
        v.rv = rv; v.rd = 5'(rd); v.fl = fl;
        v.e_stall = st; v.e_rsb = rsb; v.e_rtb = rtb; v.e_inf = inf; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int m_sum();
        int s = 0;
        for (int i = 1; i < 32; i++) s += mcnt[i];
        return s;
    endfunction

    // A source is hazardous while writes are pending, unless the only one is retiring now.
    function automatic int m_busy(input bit used, input int a, input vec_t v);
        if (!used || a == 0 || mcnt[a] == 0) return 0;
        if (v.rv && int'(v.rd) == a && mcnt[a] == 1) return 0;
        return 1;
    endfunction

    task automatic m_update(input vec_t v, input int st);
        if (!v.rst_n) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            merr = 0;
        end else if (v.fl) begin
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            int d = int'(v.dest);
            int rd = int'(v.rd);
            bit acc = v.iv && v.we && d != 0 && st == 0;
            bit ret = v.rv && rd != 0 && mcnt[rd] > 0;
            if (v.rv && rd != 0 && mcnt[rd] == 0) merr = 1;
            if (acc) mcnt[d] += 1;
            if (ret) mcnt[rd] -= 1;
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit from_tbl, input string tag);
        int e_rsb, e_rtb, e_st, e_inf, e_err;
        rst_n = v.rst_n; issue_valid = v.iv; issue_we = v.we; issue_dest = v.dest;
        rs_addr = v.rs; rs_used = v.rsu; rt_addr = v.rt; rt_used = v.rtu;
        retire_valid = v.rv; retire_dest = v.rd; flush = v.fl;
        e_rsb = m_busy(v.rsu, int'(v.rs), v);
        e_rtb = m_busy(v.rtu, int'(v.rt), v);
        e_st  = (v.iv && (e_rsb != 0 || e_rtb != 0 ||
                 (v.we && v.dest != 0 && mcnt[v.dest] == 3))) ? 1 : 0;
        e_inf = m_sum();
        e_err = int'(merr);
        if (from_tbl) begin
            e_st = v.e_stall; e_rsb = v.e_rsb; e_rtb = v.e_rtb; e_inf = v.e_inf; e_err = v.e_err;
        end
        @(negedge clk);
        chk({tag, ".stall"},    int'(stall),         e_st);
        chk({tag, ".rs_busy"},  int'(rs_busy),       e_rsb);
        chk({tag, ".rt_busy"},  int'(rt_busy),       e_rtb);
        chk({tag, ".inflight"}, int'(inflight),      e_inf);
        chk({tag, ".err"},      int'(err_underflow), e_err);
        m_update(v, int'(stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          r iv we  d  rs u  rt u  rv rd fl  st rsb rtb inf err
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0)); // idle after reset
        tbl.push_back(mk(1, 1, 1,  5,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0)); // issue r5
        tbl.push_back(mk(1, 1, 0,  0,  5, 1,  0, 0, 0,  0, 0,  1, 1, 0, 1, 0)); // read r5 -> stall
        tbl.push_back(mk(1, 1, 0,  0,  5, 1,  0, 0, 1,  5, 0,  0, 0, 0, 1, 0)); // bypass by retire
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0)); // r7 x3
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 0,  0, 0,  1, 0, 0, 3, 0)); // 4th: full
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 1,  7, 0,  1, 0, 0, 3, 0)); // held, retire r7
        tbl.push_back(mk(1, 1, 1,  7,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 2, 0)); // accepted now
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1,  7, 0,  0, 0, 0, 3, 0)); // drain r7
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1,  7, 0,  0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1,  7, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1,  9,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0)); // r9=1
        tbl.push_back(mk(1, 1, 1,  9,  0, 0,  0, 0, 1,  9, 0,  0, 0, 0, 1, 0)); // issue+retire r9
        tbl.push_back(mk(1, 1, 0,  0,  0, 0,  9, 1, 0,  0, 0,  1, 0, 1, 1, 0)); // r9 still busy
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1,  9, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0)); // issue r0
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1,  0, 0,  0, 0, 0, 0, 0)); // retire r0
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 1, 12, 0,  0, 0, 0, 0, 0)); // underflow r12
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 1,  0, 0, 0, 0, 1)); // flush keeps err
        tbl.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1,  3,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1)); // r3=2, r4=1
        tbl.push_back(mk(1, 1, 1,  3,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  4,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 2, 1));
        tbl.push_back(mk(1, 1, 1,  6,  0, 0,  0, 0, 0,  0, 1,  0, 0, 0, 3, 1)); // flush + issue r6
        tbl.push_back(mk(1, 1, 0,  0,  6, 1,  3, 1, 0,  0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1,  3,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1)); // same setup
        tbl.push_back(mk(1, 1, 1,  3,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  4,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1,  6,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 3, 1)); // reset + issue r6
        tbl.push_back(mk(1, 1, 0,  0,  6, 1,  3, 1, 0,  0, 0,  0, 0, 0, 0, 0));

        foreach (mcnt[i]) mcnt[i] = 0;
        merr = 0;
        rst_n = 1'b0; issue_valid = 0; issue_we = 0; issue_dest = '0;
        rs_addr = '0; rs_used = 0; rt_addr = '0; rt_used = 0;
        retire_valid = 0; retire_dest = '0; flush = 0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("dir%0d", i));

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst_n = ($urandom_range(0, 79) != 0);
            v.fl    = ($urandom_range(0, 39) == 0);
            v.iv    = ($urandom_range(0, 3) != 0);
            v.we    = ($urandom_range(0, 3) != 0);
            v.dest  = 5'($urandom_range(0, 7));
            v.rs    = 5'($urandom_range(0, 7));
            v.rsu   = 1'($urandom_range(0, 1));
            v.rt    = 5'($urandom_range(0, 7));
            v.rtu   = 1'($urandom_range(0, 1));
            v.rv    = ($urandom_range(0, 2) == 0);
            v.rd    = 5'($urandom_range(0, 7));
            // Mostly retire something actually pending so underflows stay occasional.
            if (v.rv && $urandom_range(0, 3) != 0) begin
                for (int k = 1; k < 8; k++) if (mcnt[k] > 0) v.rd = 5'(k);
            end
            run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
